adc_fp: RTL and testbench
=========================

Name: adc_fp

Overview:
- Receive-side counterpart of the fixed-point-to-DAC path: converts raw signed ADC samples (photodetector metric) into the signed fixed-point word used by the SPGD datapath.
- On a start request, discards SETTLE samples to let the DAC-driven optics settle, then averages 2^AVG_LOG2 samples.
- Scales the average so that ADC full scale equals ±1.0, and presents the result on a valid/ready handshake.
- Flags over-range: any accumulated sample at the ADC min or max code.

Parameters:
- FP_WIDTH, 64: output word width, signed two's complement.
- FRAC_BITS, 48: output fractional bits (Q16.48 at defaults). Must satisfy FRAC_BITS >= ADC_WIDTH-1+AVG_LOG2.
- ADC_WIDTH, 14: ADC sample width, signed two's complement, interpreted as Q1.(ADC_WIDTH-1).
- AVG_LOG2, 4: log2 of the averaged sample count N (N=16 at defaults). Range 0..8.
- SETTLE, 2: samples discarded after start. Range 0..255.

Ports:
- clk, input, 1: sole clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: acquisition request; sampled only in IDLE.
- adc_in, input, ADC_WIDTH: ADC sample.
- adc_valid, input, 1: adc_in is a new sample this cycle.
- busy, output, 1: high in any state other than IDLE.
- fp_out, output, FP_WIDTH: averaged, scaled result.
- fp_valid, output, 1: fp_out and or_flag are valid.
- fp_ready, input, 1: consumer accepts the result.
- or_flag, output, 1: over-range seen in the current result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: fp_out=0, fp_valid=0, or_flag=0, busy=0.
  - Internal: state=IDLE, accumulator=0, counters=0.
  - Reset mid-acquisition aborts it with no output.
- State machine: IDLE, SETTLE, ACQ, CONV, OUT.
- IDLE:
  - start=1 -> clear accumulator, sample counter and the internal over-range bit.
  - Next state is SETTLE, or ACQ directly if SETTLE=0.
  - adc_valid in IDLE is ignored.
- SETTLE:
  - Each adc_valid=1 cycle increments the discard counter.
  - On the SETTLE-th sample -> ACQ. That sample is not accumulated.
- ACQ:
  - Each adc_valid=1 cycle adds sign-extended adc_in to the accumulator, which is ADC_WIDTH+AVG_LOG2 bits signed and cannot overflow.
  - If adc_in equals 2^(ADC_WIDTH-1)-1 or -2^(ADC_WIDTH-1), set the internal over-range bit.
  - On the N-th accumulated sample -> CONV.
- CONV (one cycle):
  - fp_out <= sign-extended accumulator shifted left by FRAC_BITS-(ADC_WIDTH-1)-AVG_LOG2. The conversion is exact, with no rounding.
  - or_flag <= internal over-range bit; fp_valid <= 1; next state OUT.
  - adc_valid in CONV is ignored.
- OUT:
  - fp_valid, fp_out and or_flag are held stable until fp_ready=1.
  - On the cycle with fp_valid=1 and fp_ready=1 -> IDLE, fp_valid <= 0.
  - fp_out and or_flag keep their last value.
  - fp_ready while fp_valid=0 has no effect.
- Latency:
  - Last ACQ sample at cycle k -> fp_valid=1 from cycle k+2.
  - Minimum start-to-fp_valid with adc_valid continuously high: SETTLE+N+2 cycles.
- Simultaneous events:
  - start while busy is ignored; it is neither queued nor a restart.
  - A handshake completes in OUT on the same cycle start=1 -> return to IDLE; that start is ignored, so the next start is taken from IDLE.
- adc_valid gaps are allowed in SETTLE/ACQ; counters advance only on valid samples.
- No timeout: SETTLE/ACQ wait indefinitely for samples.

Test Plan:
1. Reset, start, adc_valid held high, adc_in=0x1000 (+0.5):
   - First 2 samples discarded, 16 accumulated.
   - fp_out=0x0000_8000_0000_0000, or_flag=0, fp_valid rising exactly 20 cycles after the start cycle.
2. adc_in=0x3000 (-0.5) for all samples -> fp_out=0xFFFF_8000_0000_0000, or_flag=0.
3. Settle discard check:
   - Settle samples 0x1FFF, 0x1FFF, then 16×0x0000.
   - Expect fp_out=0, or_flag=0, proving settle samples are excluded.
4. One accumulated sample=0x2000 (-1.0), rest 0x0000:
   - fp_out=0xFFFF_F000_0000_0000 (-1/16), or_flag=1.
   - The next acquisition with in-range samples gives or_flag=0.
5. Handshake hold:
   - Hold fp_ready=0 for 10 cycles with start pulsed and adc_valid toggling.
   - fp_out/fp_valid must stay stable and busy=1; no restart occurs.
   - fp_ready=1 -> fp_valid=0 and busy=0 next cycle.
6. Reset mid-acquisition:
   - Assert rst_n=0 after 5 ACQ samples -> all outputs 0 immediately.
   - A new start with 0x1000 samples yields exactly the test 1 result (accumulator not stale).

Source files
------------

// File: rtl/adc_fp.sv
// ---------------------------------------------------------------------------
// adc_fp
//
// Purpose:
//   Receive-side converter from raw signed ADC samples (photodetector metric)
//   to the signed fixed-point word used by the SPGD datapath. On a start
//   request it discards SETTLE samples so the DAC-driven optics can settle.
//   It then averages 2^AVG_LOG2 samples and scales the result so that ADC
//   full scale maps to +/-1.0. The result is presented on a valid/ready
//   handshake, together with an over-range flag.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - acquisition request, sampled only while idle
//   adc_in     - ADC sample, signed Q1.(ADC_WIDTH-1)
//   adc_valid  - adc_in carries a new sample this cycle
//   busy       - high whenever an acquisition or result is in progress
//   fp_out     - averaged, scaled result, signed Q(FP_WIDTH-FRAC_BITS).FRAC_BITS
//   fp_valid   - fp_out and or_flag are valid
//   fp_ready   - consumer accepts the result
//   or_flag    - a sample at the ADC min or max code contributed to fp_out
// ---------------------------------------------------------------------------
module adc_fp #(
  parameter int FP_WIDTH  = 64,
  parameter int FRAC_BITS = 48,
  parameter int ADC_WIDTH = 14,
  parameter int AVG_LOG2  = 4,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADC_WIDTH-1:0] adc_in,
  input  logic                 adc_valid,
  output logic                 busy,
  output logic [FP_WIDTH-1:0]  fp_out,
  output logic                 fp_valid,
  input  logic                 fp_ready,
  output logic                 or_flag
);

  // The sum of N samples needs AVG_LOG2 extra bits, so it can never overflow.
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  // The accumulator already holds avg * 2^AVG_LOG2 in Q1.(ADC_WIDTH-1).
  // Moving it to FRAC_BITS fractional bits is a pure left shift, so the
  // conversion is exact.
  localparam int SH          = FRAC_BITS - (ADC_WIDTH - 1) - AVG_LOG2;
  localparam int N_LAST      = (1 << AVG_LOG2) - 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [ADC_WIDTH-1:0] ADC_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic [ADC_WIDTH-1:0] ADC_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACQ,
    S_CONV,
    S_OUT
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         sample_cnt;
  logic [7:0]               settle_cnt;
  logic                     or_int;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [FP_WIDTH-1:0] acc_ext;

  assign sample_ext = ACC_W'(signed'(adc_in));
  assign acc_ext    = FP_WIDTH'(acc);
  assign busy       = (state != S_IDLE);

  // Acquisition sequencer: settle discard, accumulation, conversion and the
  // output handshake, all in one register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      sample_cnt <= '0;
      settle_cnt <= '0;
      or_int     <= 1'b0;
      fp_out     <= '0;
      fp_valid   <= 1'b0;
      or_flag    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc        <= '0;
            sample_cnt <= '0;
            settle_cnt <= '0;
            or_int     <= 1'b0;
            state      <= (SETTLE == 0) ? S_ACQ : S_SETTLE;
          end
        end

        // Settle samples only advance the discard counter.
        S_SETTLE: begin
          if (adc_valid) begin
            if (settle_cnt == SETTLE_LAST[7:0]) begin
              settle_cnt <= '0;
              state      <= S_ACQ;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end

        S_ACQ: begin
          if (adc_valid) begin
            acc <= acc + sample_ext;
            if (adc_in == ADC_MAX || adc_in == ADC_MIN) begin
              or_int <= 1'b1;
            end
            if (sample_cnt == N_LAST[CNT_W-1:0]) begin
              state <= S_CONV;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end

        S_CONV: begin
          fp_out   <= acc_ext <<< SH;
          or_flag  <= or_int;
          fp_valid <= 1'b1;
          state    <= S_OUT;
        end

        // fp_out and or_flag keep their value after the handshake.
        S_OUT: begin
          if (fp_ready) begin
            fp_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_fp.sv
// ---------------------------------------------------------------------------
// tb_adc_fp
//
// Purpose:
//   Directed self-checking bench for adc_fp at default parameters
//   (Q16.48 output, 14-bit ADC, 16-sample average, 2 settle samples).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_fp;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] adc_in;
  logic        adc_valid;
  logic        busy;
  logic [63:0] fp_out;
  logic        fp_valid;
  logic        fp_ready;
  logic        or_flag;

  int total = 0;
  int bad   = 0;
  bit got_valid;

  adc_fp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .adc_in   (adc_in),
    .adc_valid(adc_valid),
    .busy     (busy),
    .fp_out   (fp_out),
    .fp_valid (fp_valid),
    .fp_ready (fp_ready),
    .or_flag  (or_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step, ending at the falling edge where we drive and sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full acquisition: two settle samples, then first sample, then 15 of
  // rest. Optionally idles one cycle between samples. Waits (bounded) for
  // fp_valid and reports whether it arrived in got_valid.
  task automatic run_acq(input logic [13:0] st0, input logic [13:0] st1,
                         input logic [13:0] first, input logic [13:0] rest,
                         input bit gaps);
    logic [13:0] v;
    start     = 1'b1;
    adc_valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      v = (i == 0) ? st0 : (i == 1) ? st1 : (i == 2) ? first : rest;
      adc_in    = v;
      adc_valid = 1'b1;
      step();
      adc_valid = 1'b0;
      if (gaps) step();
    end
    got_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fp_valid) begin
        got_valid = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Completes the handshake in one cycle.
  task automatic accept();
    fp_ready = 1'b1;
    step();
    fp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (fp_out !== 64'd0) begin bad++; $display("[TB] FAIL reset_fp_out: got %h expected 0", fp_out); end
    total++; if (fp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fp_valid: got %b expected 0", fp_valid); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL reset_or_flag: got %b expected 0", or_flag); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // +0.5 on every sample with adc_valid held high: checks value and latency.
  task automatic test_half_pos();
    int cyc = 0;
    start     = 1'b1;
    adc_valid = 1'b1;
    adc_in    = 14'h1000;
    while (cyc < 60) begin
      step();
      cyc++;
      start = 1'b0;
      if (fp_valid) break;
    end
    total++; if (cyc !== 20) begin bad++; $display("[TB] FAIL latency: got %0d expected 20", cyc); end
    total++; if (fp_out !== 64'h0000_8000_0000_0000) begin bad++; $display("[TB] FAIL half_pos_value: got %h expected 0000800000000000", fp_out); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL half_pos_or: got %b expected 0", or_flag); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL half_pos_busy: got %b expected 1", busy); end
    adc_valid = 1'b0;
    accept();
    total++; if (fp_valid !== 1'b0) begin bad++; $display("[TB] FAIL half_pos_accept: got %b expected 0", fp_valid); end
  endtask

  // -0.5 on every sample, with idle cycles between samples.
  task automatic test_half_neg_gaps();
    run_acq(14'h3000, 14'h3000, 14'h3000, 14'h3000, 1'b1);
    total++; if (got_valid !== 1'b1) begin bad++; $display("[TB] FAIL half_neg_timeout: got %b expected 1", got_valid); end
    total++; if (fp_out !== 64'hFFFF_8000_0000_0000) begin bad++; $display("[TB] FAIL half_neg_value: got %h expected ffff800000000000", fp_out); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL half_neg_or: got %b expected 0", or_flag); end
    accept();
  endtask

  // Full-scale settle samples must not reach the average or the flag.
  task automatic test_settle_discard();
    run_acq(14'h1FFF, 14'h1FFF, 14'h0000, 14'h0000, 1'b0);
    total++; if (got_valid !== 1'b1) begin bad++; $display("[TB] FAIL settle_timeout: got %b expected 1", got_valid); end
    total++; if (fp_out !== 64'd0) begin bad++; $display("[TB] FAIL settle_value: got %h expected 0", fp_out); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL settle_or: got %b expected 0", or_flag); end
    accept();
  endtask

  // One -1.0 sample gives -1/16 and the over-range flag; next run clears it.
  task automatic test_over_range();
    run_acq(14'h0000, 14'h0000, 14'h2000, 14'h0000, 1'b0);
    total++; if (fp_out !== 64'hFFFF_F000_0000_0000) begin bad++; $display("[TB] FAIL or_value: got %h expected fffff00000000000", fp_out); end
    total++; if (or_flag !== 1'b1) begin bad++; $display("[TB] FAIL or_set: got %b expected 1", or_flag); end
    accept();
    run_acq(14'h1000, 14'h1000, 14'h1000, 14'h1000, 1'b0);
    total++; if (fp_out !== 64'h0000_8000_0000_0000) begin bad++; $display("[TB] FAIL or_next_value: got %h expected 0000800000000000", fp_out); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL or_clear: got %b expected 0", or_flag); end
    accept();
  endtask

  // Result held under backpressure; start/adc_valid ignored; start on the
  // handshake cycle is not taken.
  task automatic test_handshake_hold();
    int unstable = 0;
    run_acq(14'h0800, 14'h0800, 14'h0800, 14'h0800, 1'b0);
    total++; if (fp_out !== 64'h0000_4000_0000_0000) begin bad++; $display("[TB] FAIL hold_value: got %h expected 0000400000000000", fp_out); end
    adc_in = 14'h1FFF;
    for (int i = 0; i < 10; i++) begin
      start     = (i % 3 == 0);
      adc_valid = i[0];
      step();
      if (fp_valid !== 1'b1 || busy !== 1'b1 || fp_out !== 64'h0000_4000_0000_0000
          || or_flag !== 1'b0) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", unstable); end
    start     = 1'b1;
    adc_valid = 1'b0;
    fp_ready  = 1'b1;
    step();
    start    = 1'b0;
    fp_ready = 1'b0;
    total++; if (fp_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_release_valid: got %b expected 0", fp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL hold_release_busy: got %b expected 0", busy); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL hold_no_restart: got %b expected 0", busy); end
    total++; if (fp_out !== 64'h0000_4000_0000_0000) begin bad++; $display("[TB] FAIL hold_keep_value: got %h expected 0000400000000000", fp_out); end
  endtask

  // Reset after 5 accumulated samples, then a clean acquisition.
  task automatic test_mid_reset();
    start     = 1'b1;
    adc_valid = 1'b1;
    adc_in    = 14'h1FFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
    adc_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    total++; if (fp_out !== 64'd0) begin bad++; $display("[TB] FAIL mid_reset_fp_out: got %h expected 0", fp_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    total++; if (fp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", fp_valid); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_or: got %b expected 0", or_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_acq(14'h1000, 14'h1000, 14'h1000, 14'h1000, 1'b0);
    total++; if (got_valid !== 1'b1) begin bad++; $display("[TB] FAIL after_reset_timeout: got %b expected 1", got_valid); end
    total++; if (fp_out !== 64'h0000_8000_0000_0000) begin bad++; $display("[TB] FAIL after_reset_value: got %h expected 0000800000000000", fp_out); end
    total++; if (or_flag !== 1'b0) begin bad++; $display("[TB] FAIL after_reset_or: got %b expected 0", or_flag); end
    accept();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    adc_in    = '0;
    adc_valid = 1'b0;
    fp_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_half_pos();
    test_half_neg_gaps();
    test_settle_discard();
    test_over_range();
    test_handshake_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
